// File: rtl/add_job_sequencer.sv
// Job sequencer for the add engine: splits a host job into engine-sized
// chunks, kicks the engine and read master per chunk, and waits for both
// read and write completion before advancing the addresses.
module add_job_sequencer #(
   parameter int unsigned CHUNK_WORDS    = 1023,
   parameter int unsigned BYTES_PER_WORD = 64
) (
   input  logic        aclk,
   input  logic        areset_n,
   input  logic        ap_start,
   output logic        ap_idle,
   output logic        ap_done,
   input  logic [31:0] total_words,
   input  logic        mode_in,
   input  logic [63:0] src_addr,
   input  logic [63:0] dst_addr,
   output logic        op_start,
   output logic        mode,
   output logic [9:0]  words_num,
   output logic [63:0] eng_write_addr,
   output logic        rmst_req,
   output logic [63:0] rmst_xfer_addr,
   output logic [63:0] rmst_xfer_size,
   input  logic        rmst_done,
   input  logic        wmst_done,
   output logic [21:0] chunk_idx
);

   localparam int unsigned CNT_W   = 32;
   localparam int unsigned ADDR_W  = 64;
   localparam int unsigned WORDS_W = 10;
   localparam int unsigned IDX_W   = 22;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_REQ,
      S_WAIT,
      S_NEXT,
      S_DONE
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    remaining_q, remaining_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [IDX_W-1:0]    chunk_idx_q, chunk_idx_d;
   logic                mode_q, mode_d;
   logic [WORDS_W-1:0]  words_num_q, words_num_d;
   logic [ADDR_W-1:0]   eng_write_addr_q, eng_write_addr_d;
   logic [ADDR_W-1:0]   rmst_xfer_addr_q, rmst_xfer_addr_d;
   logic [ADDR_W-1:0]   rmst_xfer_size_q, rmst_xfer_size_d;
   logic                flag_r_q, flag_r_d;
   logic                flag_w_q, flag_w_d;
   logic                ap_idle_q, ap_idle_d;
   logic                ap_done_q, ap_done_d;
   logic                op_start_q, op_start_d;
   logic                rmst_req_q, rmst_req_d;

   logic [WORDS_W-1:0]  chunk_words;
   logic [ADDR_W-1:0]   step_bytes;

   // Next-state, datapath and output decode; pulse outputs follow the next state
   always_comb begin
      state_d          = state_q;
      remaining_d      = remaining_q;
      rd_ptr_d         = rd_ptr_q;
      wr_ptr_d         = wr_ptr_q;
      chunk_idx_d      = chunk_idx_q;
      mode_d           = mode_q;
      words_num_d      = words_num_q;
      eng_write_addr_d = eng_write_addr_q;
      rmst_xfer_addr_d = rmst_xfer_addr_q;
      rmst_xfer_size_d = rmst_xfer_size_q;
      flag_r_d         = flag_r_q;
      flag_w_d         = flag_w_q;
      step_bytes       = ADDR_W'(words_num_q) * ADDR_W'(BYTES_PER_WORD);
      chunk_words      = '0;

      case (state_q)
         S_IDLE: begin
            if (ap_start) begin
               remaining_d = total_words;
               mode_d      = mode_in;
               rd_ptr_d    = src_addr;
               wr_ptr_d    = dst_addr;
               chunk_idx_d = '0;
               state_d     = (total_words == '0) ? S_DONE : S_START;
            end
         end
         S_START: begin
            flag_r_d = 1'b0;
            flag_w_d = 1'b0;
            state_d  = S_REQ;
         end
         S_REQ: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (rmst_done) flag_r_d = 1'b1;
            if (wmst_done) flag_w_d = 1'b1;
            if ((flag_r_q | rmst_done) && (flag_w_q | wmst_done)) state_d = S_NEXT;
         end
         S_NEXT: begin
            remaining_d = remaining_q - CNT_W'(words_num_q);
            rd_ptr_d    = rd_ptr_q + step_bytes;
            wr_ptr_d    = wr_ptr_q + step_bytes;
            chunk_idx_d = chunk_idx_q + IDX_W'(1);
            state_d     = (remaining_d == '0) ? S_DONE : S_START;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Chunk parameters are loaded on entry to START so they are valid with op_start
      if (state_d == S_START) begin
         chunk_words      = (remaining_d > CNT_W'(CHUNK_WORDS)) ? WORDS_W'(CHUNK_WORDS)
                                                                : remaining_d[WORDS_W-1:0];
         words_num_d      = chunk_words;
         eng_write_addr_d = wr_ptr_d;
         rmst_xfer_addr_d = rd_ptr_d;
         rmst_xfer_size_d = ADDR_W'(chunk_words) * ADDR_W'(BYTES_PER_WORD);
      end

      ap_idle_d  = (state_d == S_IDLE);
      ap_done_d  = (state_d == S_DONE);
      op_start_d = (state_d == S_START);
      rmst_req_d = (state_d == S_REQ);
   end

   // State and output registers
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state_q          <= S_IDLE;
         remaining_q      <= '0;
         rd_ptr_q         <= '0;
         wr_ptr_q         <= '0;
         chunk_idx_q      <= '0;
         mode_q           <= 1'b0;
         words_num_q      <= '0;
         eng_write_addr_q <= '0;
         rmst_xfer_addr_q <= '0;
         rmst_xfer_size_q <= '0;
         flag_r_q         <= 1'b0;
         flag_w_q         <= 1'b0;
         ap_idle_q        <= 1'b1;
         ap_done_q        <= 1'b0;
         op_start_q       <= 1'b0;
         rmst_req_q       <= 1'b0;
      end else begin
         state_q          <= state_d;
         remaining_q      <= remaining_d;
         rd_ptr_q         <= rd_ptr_d;
         wr_ptr_q         <= wr_ptr_d;
         chunk_idx_q      <= chunk_idx_d;
         mode_q           <= mode_d;
         words_num_q      <= words_num_d;
         eng_write_addr_q <= eng_write_addr_d;
         rmst_xfer_addr_q <= rmst_xfer_addr_d;
         rmst_xfer_size_q <= rmst_xfer_size_d;
         flag_r_q         <= flag_r_d;
         flag_w_q         <= flag_w_d;
         ap_idle_q        <= ap_idle_d;
         ap_done_q        <= ap_done_d;
         op_start_q       <= op_start_d;
         rmst_req_q       <= rmst_req_d;
      end
   end

   assign ap_idle        = ap_idle_q;
   assign ap_done        = ap_done_q;
   assign op_start       = op_start_q;
   assign rmst_req       = rmst_req_q;
   assign mode           = mode_q;
   assign words_num      = words_num_q;
   assign eng_write_addr = eng_write_addr_q;
   assign rmst_xfer_addr = rmst_xfer_addr_q;
   assign rmst_xfer_size = rmst_xfer_size_q;
   assign chunk_idx      = chunk_idx_q;

endmodule
